i2s_dac_tx: RTL and testbench

I2S_DAC_TX -- requirements
Module: i2s_dac_tx

---
 rtl/audio_pkg.sv | 13 +
 rtl/i2s_dac_tx.sv | 139 +++++++++++++
 tb/tb_i2s_dac_tx.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared audio definitions used by the I2S transmit, receive and DSP paths.
package audio_pkg;

  localparam int SAMPLE_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_DELAY = 2'd1,
    S_SHIFT = 2'd2,
    S_PAD   = 2'd3
  } tx_state_t;

endpackage

// File: rtl/i2s_dac_tx.sv
// I2S transmitter toward the codec DAC: double-buffers a left/right pair and
// shifts it out MSB-first with the standard one-bit delay after each LRCK edge.
module i2s_dac_tx
  import audio_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEFAULT,
  parameter int HALF_MIN = 18
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_lrck,
  input  logic                i_valid,
  input  logic [SAMPLE_W-1:0] i_data,
  input  logic                i_mono,
  output logic                o_dacdat,
  output logic                o_ready,
  output logic                o_underrun,
  output logic                o_overflow
);

  localparam int   CNT_W  = $clog2(SAMPLE_W + 1);
  localparam logic SLOT_L = 1'b0;
  localparam logic SLOT_R = 1'b1;

  // A half shorter than the delay slot plus one slot per bit cannot carry a full word.
  if (HALF_MIN < SAMPLE_W + 1) begin : g_half_min_check
    $error("i2s_dac_tx: HALF_MIN too small for SAMPLE_W");
  end

  logic                lrck_q;
  logic                edge_det;
  logic                left_edge;
  logic                right_edge;
  logic                wr_ok;
  logic                pfull;
  logic                slot;
  logic                sel_r;
  logic [SAMPLE_W-1:0] pl;
  logic [SAMPLE_W-1:0] pr;
  logic [SAMPLE_W-1:0] al;
  logic [SAMPLE_W-1:0] ar;
  logic [SAMPLE_W-1:0] word;
  logic [SAMPLE_W-1:0] sh;
  logic [CNT_W-1:0]    cnt;
  tx_state_t           state;

  // lrck_q keeps following i_lrck through reset, so a release mid-half sees no false edge.
  always_ff @(posedge i_clk) begin
    lrck_q <= i_lrck;
  end

  assign edge_det   = (i_lrck != lrck_q);
  assign left_edge  = edge_det & ~i_lrck;
  assign right_edge = edge_det & i_lrck;
  assign wr_ok      = i_valid & ~pfull;
  assign o_ready    = ~pfull;
  assign word       = sel_r ? ar : al;

  // The left-edge transfer reads the pending pair before any same-cycle write lands.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pl         <= '0;
      pr         <= '0;
      al         <= '0;
      ar         <= '0;
      pfull      <= 1'b0;
      slot       <= SLOT_L;
      o_underrun <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      o_underrun <= 1'b0;
      o_overflow <= i_valid & pfull;
      if (left_edge) begin
        if (pfull) begin
          al    <= pl;
          ar    <= pr;
          pfull <= 1'b0;
        end else begin
          al         <= '0;
          ar         <= '0;
          o_underrun <= 1'b1;
        end
      end
      if (wr_ok) begin
        if (i_mono) begin
          pl    <= i_data;
          pr    <= i_data;
          pfull <= 1'b1;
        end else if (slot == SLOT_L) begin
          pl   <= i_data;
          slot <= SLOT_R;
        end else begin
          pr    <= i_data;
          pfull <= 1'b1;
          slot  <= SLOT_L;
        end
      end
    end
  end

  // Any accepted edge restarts the word, so a short half simply truncates the previous one.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= S_WAIT;
      sel_r    <= 1'b0;
      sh       <= '0;
      cnt      <= '0;
      o_dacdat <= 1'b0;
    end else if (left_edge || (right_edge && state != S_WAIT)) begin
      state    <= S_DELAY;
      sel_r    <= i_lrck;
      cnt      <= '0;
      o_dacdat <= 1'b0;
    end else begin
      case (state)
        S_DELAY: begin
          state    <= S_SHIFT;
          o_dacdat <= word[SAMPLE_W-1];
          sh       <= {word[SAMPLE_W-2:0], 1'b0};
          cnt      <= CNT_W'(SAMPLE_W - 1);
        end
        S_SHIFT: begin
          if (cnt == '0) begin
            state    <= S_PAD;
            o_dacdat <= 1'b0;
          end else begin
            o_dacdat <= sh[SAMPLE_W-1];
            sh       <= {sh[SAMPLE_W-2:0], 1'b0};
            cnt      <= cnt - 1'b1;
          end
        end
        default: begin
          o_dacdat <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Directed bench for i2s_dac_tx: drives LRCK halves cycle by cycle and rebuilds each serial word.
module tb_i2s_dac_tx;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         lrck = 1'b1;
  logic         valid = 1'b0;
  logic         mono = 1'b0;
  logic [W-1:0] data = '0;
  logic         dacdat;
  logic         ready;
  logic         underrun;
  logic         overflow;

  int           checks = 0;
  int           errors = 0;
  int           vcyc[4];
  logic [W-1:0] vdat[4];
  logic [W-1:0] cap_word;
  logic         zero_ok;
  int           n_under;
  int           n_over;
  logic         ready_end;

  i2s_dac_tx #(.SAMPLE_W(W), .HALF_MIN(18)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_lrck     (lrck),
    .i_valid    (valid),
    .i_data     (data),
    .i_mono     (mono),
    .o_dacdat   (dacdat),
    .o_ready    (ready),
    .o_underrun (underrun),
    .o_overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clearValids();
    for (int i = 0; i < 4; i++) begin
      vcyc[i] = -1;
      vdat[i] = '0;
    end
  endtask

  // One LRCK half of len cycles; sample c is taken after the c-th rising edge of the half.
  task automatic applyStimulus(input logic lr, input int len);
    cap_word = '0;
    zero_ok  = 1'b1;
    n_under  = 0;
    n_over   = 0;
    for (int c = 0; c < len; c++) begin
      lrck  = lr;
      valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (vcyc[i] == c) begin
          valid = 1'b1;
          data  = vdat[i];
        end
      end
      @(negedge clk);
      if (c >= 1 && c <= W) cap_word[W-c] = dacdat;
      else if (dacdat !== 1'b0) zero_ok = 1'b0;
      if (underrun) n_under++;
      if (overflow) n_over++;
      ready_end = ready;
    end
    valid = 1'b0;
    clearValids();
  endtask

  initial begin
    clearValids();
    repeat (4) @(negedge clk);
    checkOutput("rst_dacdat", 32'(dacdat), 32'h0);
    checkOutput("rst_ready", 32'(ready), 32'h1);
    checkOutput("rst_underrun", 32'(underrun), 32'h0);
    checkOutput("rst_overflow", 32'(overflow), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_ready", 32'(ready), 32'h1);

    // Stereo pair loaded while still waiting for the first left edge
    vcyc[0] = 5; vdat[0] = 16'h8001;
    vcyc[1] = 7; vdat[1] = 16'h7FFE;
    applyStimulus(1'b1, 32);
    checkOutput("wait_word", 32'(cap_word), 32'h0);
    checkOutput("wait_zero", 32'(zero_ok), 32'h1);
    checkOutput("pair_ready", 32'(ready_end), 32'h0);
    applyStimulus(1'b0, 32);
    checkOutput("st_left", 32'(cap_word), 32'h8001);
    checkOutput("st_left_zero", 32'(zero_ok), 32'h1);
    checkOutput("st_left_under", 32'(n_under), 32'h0);
    checkOutput("st_left_ready", 32'(ready_end), 32'h1);

    // Mono sample written during the right half
    mono = 1'b1;
    vcyc[0] = 3; vdat[0] = 16'h1234;
    applyStimulus(1'b1, 32);
    checkOutput("st_right", 32'(cap_word), 32'h7FFE);
    checkOutput("st_right_zero", 32'(zero_ok), 32'h1);
    checkOutput("mono_ready_low", 32'(ready_end), 32'h0);
    mono = 1'b0;
    applyStimulus(1'b0, 32);
    checkOutput("mono_left", 32'(cap_word), 32'h1234);
    checkOutput("mono_ready_back", 32'(ready_end), 32'h1);
    applyStimulus(1'b1, 32);
    checkOutput("mono_right", 32'(cap_word), 32'h1234);

    // Underrun, then overflow on a third sample
    applyStimulus(1'b0, 32);
    checkOutput("ur_count", 32'(n_under), 32'h1);
    checkOutput("ur_left", 32'(cap_word), 32'h0);
    checkOutput("ur_ready", 32'(ready_end), 32'h1);
    vcyc[0] = 2; vdat[0] = 16'hA5A5;
    vcyc[1] = 4; vdat[1] = 16'h5A5A;
    vcyc[2] = 6; vdat[2] = 16'hFFFF;
    applyStimulus(1'b1, 32);
    checkOutput("ur_right", 32'(cap_word), 32'h0);
    checkOutput("ov_count", 32'(n_over), 32'h1);
    checkOutput("ov_ready", 32'(ready_end), 32'h0);
    applyStimulus(1'b0, 32);
    checkOutput("ov_left", 32'(cap_word), 32'hA5A5);
    checkOutput("ov_left_under", 32'(n_under), 32'h0);

    // Pair completed on the left-edge cycle itself
    vcyc[0] = 10; vdat[0] = 16'h1111;
    applyStimulus(1'b1, 32);
    checkOutput("ov_right", 32'(cap_word), 32'h5A5A);
    checkOutput("half_pair_ready", 32'(ready_end), 32'h1);
    vcyc[0] = 0; vdat[0] = 16'h2222;
    applyStimulus(1'b0, 32);
    checkOutput("col_under", 32'(n_under), 32'h1);
    checkOutput("col_left", 32'(cap_word), 32'h0);
    checkOutput("col_ready", 32'(ready_end), 32'h0);
    checkOutput("col_over", 32'(n_over), 32'h0);
    applyStimulus(1'b1, 32);
    checkOutput("col_right", 32'(cap_word), 32'h0);
    applyStimulus(1'b0, 32);
    checkOutput("col_left2", 32'(cap_word), 32'h1111);
    vcyc[0] = 3; vdat[0] = 16'hFFFF;
    vcyc[1] = 5; vdat[1] = 16'hC3C3;
    applyStimulus(1'b1, 32);
    checkOutput("col_right2", 32'(cap_word), 32'h2222);

    // Reset while bit 7 of a left word is about to launch
    applyStimulus(1'b0, 9);
    checkOutput("rst_partial", 32'(cap_word), 32'hFF00);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_dacdat", 32'(dacdat), 32'h0);
    checkOutput("mid_rst_ready", 32'(ready), 32'h1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 20);
    checkOutput("post_rst_left", 32'(cap_word), 32'h0);
    checkOutput("post_rst_zero", 32'(zero_ok), 32'h1);
    vcyc[0] = 4; vdat[0] = 16'h0F0F;
    vcyc[1] = 6; vdat[1] = 16'h00FF;
    applyStimulus(1'b1, 32);
    checkOutput("rst_right_ignored", 32'(cap_word), 32'h0);
    checkOutput("rst_right_zero", 32'(zero_ok), 32'h1);
    applyStimulus(1'b0, 32);
    checkOutput("resume_left", 32'(cap_word), 32'h0F0F);
    checkOutput("resume_under", 32'(n_under), 32'h0);

    // Short 12-cycle left half truncates after 11 bits
    vcyc[0] = 4; vdat[0] = 16'hFFFF;
    vcyc[1] = 6; vdat[1] = 16'hAAAA;
    applyStimulus(1'b1, 32);
    checkOutput("resume_right", 32'(cap_word), 32'h00FF);
    applyStimulus(1'b0, 12);
    checkOutput("short_left", 32'(cap_word), 32'hFFE0);
    checkOutput("short_left_zero", 32'(zero_ok), 32'h1);
    applyStimulus(1'b1, 32);
    checkOutput("short_next_right", 32'(cap_word), 32'hAAAA);
    checkOutput("short_next_zero", 32'(zero_ok), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
